// File: rtl/clock_divider_pkg.sv
// ============================================================================
// Module      : clock_divider_pkg
// Description : Shared state encoding and divisor floor for clock_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package clock_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } div_state_t;

    localparam int DIV_MIN = 2;

endpackage

`default_nettype wire

// File: rtl/clock_divider_cnt.sv
// ============================================================================
// Module      : clock_divider_cnt
// Description : Period counter; wraps at Neff-1 and flags the high phase of
//               the next cycle. Honours CLOCK_DIVIDER_ODD_DUTY50_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clock_divider_cnt
    import clock_divider_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div_act,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             hi
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] neff;
    logic [CNT_W-1:0] high_len;

    always_comb begin
        neff = (div_act < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div_act;
`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
        // Odd divisors get their extra half cycle from the falling-edge flop.
        high_len = neff >> 1;
`else
        high_len = (neff >> 1) + CNT_W'(neff[0]);
`endif
        wrap  = run && (cnt_q == (neff - CNT_W'(1)));
        cnt_d = '0;
        if (run && !wrap) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // hi describes the cycle that starts at the next edge.
        hi = (cnt_d < high_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/clock_divider.sv
// ============================================================================
// Module      : clock_divider
// Description : Glitch-free programmable clock divider with tick strobe and
//               boundary-synchronised divisor reload.
//               Option macro: CLOCK_DIVIDER_ODD_DUTY50_EN (50% duty, odd N).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             load_ack,
    output logic             busy
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_rise_q, clk_rise_d;
    logic             tick_q, tick_d;
    logic             load_ack_q, load_ack_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             hi;
    logic             run;
    logic             boundary;
    logic             apply;
    logic             running_d;

    assign run = (state_q != IDLE);

    clock_divider_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_act (div_act_q),
        .run     (run),
        .cnt     (cnt),
        .wrap    (wrap),
        .hi      (hi)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = STOP;
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A period starts either at a wrap or from the parked idle counter.
        boundary   = wrap || ((state_q == IDLE) && (cnt == '0));
        apply      = pend_vld_q && boundary;
        div_act_d  = apply ? div_pend_q : div_act_q;
        div_pend_d = div_load ? div_val : div_pend_q;
        pend_vld_d = div_load ? 1'b1 : (apply ? 1'b0 : pend_vld_q);

        running_d  = (state_d != IDLE);
        clk_rise_d = running_d && hi;
        tick_d     = running_d && boundary;
        load_ack_d = apply;
        busy_d     = running_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_act_q  <= CNT_W'(DIV_MIN);
            div_pend_q <= '0;
            pend_vld_q <= 1'b0;
            clk_rise_q <= 1'b0;
            tick_q     <= 1'b0;
            load_ack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_vld_q <= pend_vld_d;
            clk_rise_q <= clk_rise_d;
            tick_q     <= tick_d;
            load_ack_q <= load_ack_d;
            busy_q     <= busy_d;
        end
    end

`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
    logic odd_act;
    logic clk_fall_q, clk_fall_d;

    // Divisors 0 and 1 run as 2, so only odd values above 1 are odd.
    always_comb begin
        odd_act    = div_act_q[0] && (div_act_q != CNT_W'(1));
        clk_fall_d = clk_rise_q && odd_act;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_fall_q <= 1'b0;
        end else begin
            clk_fall_q <= clk_fall_d;
        end
    end

    assign clk_out = clk_rise_q | clk_fall_q;
`else
    assign clk_out = clk_rise_q;
`endif

    assign tick     = tick_q;
    assign load_ack = load_ack_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_divider.sv
// ============================================================================
// Module      : tb_clock_divider
// Description : Directed self-checking bench for clock_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clock_divider;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b0;
    logic       div_load = 1'b0;
    logic [7:0] div_val  = 8'd0;
    logic       clk_out;
    logic       tick;
    logic       load_ack;
    logic       busy;

    int  total = 0;
    int  bad   = 0;
    time t_rise = 0;
    time per    = 0;
    time high   = 0;

    clock_divider #(
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .load_ack (load_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk_out) begin
        per    = $time - t_rise;
        t_rise = $time;
    end

    always @(negedge clk_out) high = $time - t_rise;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        div_val  = v;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL reset_clk_out got=%b want=0", clk_out); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
        total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL reset_load_ack got=%b want=0", load_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_n4();
        int ticks = 0;
        load(8'd4);
        total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL n4_ack_early got=%b want=0", load_ack); end
        step();
        total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL n4_ack_idle got=%b want=1", load_ack); end
        en = 1'b1;
        step();
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL n4_first_tick got=%b want=1", tick); end
        total++; if (clk_out !== 1'b1) begin bad++; $display("FAIL n4_first_clk got=%b want=1", clk_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL n4_busy got=%b want=1", busy); end
        repeat (16) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        total++; if (ticks !== 4) begin bad++; $display("FAIL n4_tick_count got=%0d want=4", ticks); end
        total++; if (per !== 40) begin bad++; $display("FAIL n4_period got=%0d want=40", per); end
        total++; if (high !== 20) begin bad++; $display("FAIL n4_high got=%0d want=20", high); end
    endtask

    task automatic test_n5();
        int acks = 0;
        time want_high;
`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
        want_high = 25;
`else
        want_high = 30;
`endif
        load(8'd5);
        repeat (25) begin
            if (load_ack === 1'b1) acks++;
            step();
        end
        total++; if (acks !== 1) begin bad++; $display("FAIL n5_acks got=%0d want=1", acks); end
        total++; if (per !== 50) begin bad++; $display("FAIL n5_period got=%0d want=50", per); end
        total++; if (high !== want_high) begin bad++; $display("FAIL n5_high got=%0d want=%0d", high, want_high); end
    endtask

    task automatic test_small_div();
        logic [7:0] vals [2];
        vals[0] = 8'd0;
        vals[1] = 8'd1;
        for (int k = 0; k < 2; k++) begin
            int acks = 0;
            load(vals[k]);
            repeat (20) begin
                if (load_ack === 1'b1) acks++;
                step();
            end
            total++; if (acks !== 1) begin bad++; $display("FAIL small%0d_acks got=%0d want=1", vals[k], acks); end
            total++; if (per !== 20) begin bad++; $display("FAIL small%0d_period got=%0d want=20", vals[k], per); end
            total++; if (high !== 10) begin bad++; $display("FAIL small%0d_high got=%0d want=10", vals[k], high); end
        end
    endtask

    task automatic test_midload();
        bit ok;
        int ticks = 0;
        load(8'd4);
        repeat (12) step();
        wait_tick(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_sync got=timeout want=tick"); end
        load(8'd8);
        total++; if (clk_out !== 1'b1) begin bad++; $display("FAIL mid_high_phase got=%b want=1", clk_out); end
        total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL mid_ack_early got=%b want=0", load_ack); end
        step();
        step();
        step();
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL mid_tick_at_ack got=%b want=1", tick); end
        total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL mid_ack got=%b want=1", load_ack); end
        repeat (7) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        total++; if (ticks !== 0) begin bad++; $display("FAIL mid_early_ticks got=%0d want=0", ticks); end
        step();
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL mid_tick80 got=%b want=1", tick); end
        total++; if (per !== 80) begin bad++; $display("FAIL mid_period got=%0d want=80", per); end
        total++; if (high !== 40) begin bad++; $display("FAIL mid_high got=%0d want=40", high); end
    endtask

    task automatic test_stop();
        bit seen  = 1'b0;
        bit gap   = 1'b0;
        int ticks = 0;
        load(8'd6);
        for (int i = 0; i < 20; i++) begin
            step();
            if (load_ack === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL stop_ack got=timeout want=ack"); end
        step();
        en = 1'b0;
        repeat (4) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy_last got=%b want=1", busy); end
        step();
        if (tick === 1'b1) ticks++;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_idle_busy got=%b want=0", busy); end
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL stop_idle_clk got=%b want=0", clk_out); end
        repeat (3) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        total++; if (ticks !== 0) begin bad++; $display("FAIL stop_extra_ticks got=%0d want=0", ticks); end

        en = 1'b1;
        step();
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL stop_restart got=%b want=1", tick); end
        step();
        en = 1'b0;
        step();
        if (busy !== 1'b1) gap = 1'b1;
        step();
        if (busy !== 1'b1) gap = 1'b1;
        en = 1'b1;
        step();
        if (busy !== 1'b1) gap = 1'b1;
        step();
        if (busy !== 1'b1) gap = 1'b1;
        step();
        total++; if (gap !== 1'b0) begin bad++; $display("FAIL resume_busy_gap got=%b want=0", gap); end
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL resume_tick got=%b want=1", tick); end
        total++; if (per !== 60) begin bad++; $display("FAIL resume_period got=%0d want=60", per); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int acks = 0;
        wait_tick(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_sync got=timeout want=tick"); end
        repeat (5) step();
        load(8'd3);
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL rstmid_pre_tick got=%b want=1", tick); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL rstmid_clk got=%b want=0", clk_out); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rstmid_tick got=%b want=0", tick); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        step();
        step();
        rst_n = 1'b1;
        repeat (12) begin
            step();
            if (load_ack === 1'b1) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL rstmid_lost_load got=%0d want=0", acks); end
        total++; if (per !== 20) begin bad++; $display("FAIL rstmid_period got=%0d want=20", per); end
        total++; if (high !== 10) begin bad++; $display("FAIL rstmid_high got=%0d want=10", high); end
    endtask

    initial begin
        test_reset();
        test_n4();
        test_n5();
        test_small_div();
        test_midload();
        test_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
